// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 5-stage core pipeline.
// It drives the PC and pipeline-register load enables and the bubble
// (flush) controls. It resolves load-use hazards, taken-branch flushes and
// multi-cycle data-memory accesses, and supports a debug halt/resume.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall-cycle
// performance counter. Without it, o_stall_cycles is tied to 0.
//
// Parameters:
//   MEM_TIMEOUT       maximum number of MEM_WAIT cycles before a forced
//                     release (legal range 1..65535)
// Ports:
//   i_clk, i_rst_n    clock; asynchronous active-low reset
//   i_id_*            ID-stage source indices and their use flags
//   i_ex_*            EX-stage destination, load flag, taken branch
//   i_mem_is_mem      EX/MEM register holds a load or store
//   i_dmem_ready      data memory completes the access this cycle
//   i_dbg_halt_req    debug halt request (level)
//   i_dbg_resume      debug resume (pulse)
//   o_*_en            PC and pipeline-register load enables
//   o_*_flush         load a bubble into IF/ID or ID/EX on this edge
//   o_dmem_req        data-memory access request
//   o_halted          pipeline frozen by debug
//   o_mem_timeout_err sticky memory-timeout flag (cleared only by reset)
//   o_stall_cycles    count of cycles with o_pc_en low (saturating)
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs1_idx,
  input  logic [4:0]  i_id_rs2_idx,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_ex_rd_idx,
  input  logic        i_ex_is_load,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_is_mem,
  input  logic        i_dmem_ready,
  input  logic        i_dbg_halt_req,
  input  logic        i_dbg_resume,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_id_ex_en,
  output logic        o_ex_mem_en,
  output logic        o_mem_wb_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_dmem_req,
  output logic        o_halted,
  output logic        o_mem_timeout_err,
  output logic [31:0] o_stall_cycles
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

  state_e      r_state_q, w_state_d;
  logic [15:0] r_wait_cnt_q, w_wait_cnt_d;
  logic        r_err_q, w_err_d;

  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic w_if_id_flush, w_id_ex_flush, w_dmem_req, w_halted;
  logic w_mem_stall, w_load_use, w_timeout;
  logic [16:0] w_cnt_inc;

  assign w_mem_stall = i_mem_is_mem & ~i_dmem_ready;
  assign w_load_use  = i_ex_is_load & (i_ex_rd_idx != 5'd0) &
                       ((i_id_uses_rs1 & (i_id_rs1_idx == i_ex_rd_idx)) |
                        (i_id_uses_rs2 & (i_id_rs2_idx == i_ex_rd_idx)));

  // Timeout fires in the MEM_WAIT cycle where the counter reaches MEM_TIMEOUT.
  assign w_cnt_inc = {1'b0, r_wait_cnt_q} + 17'd1;
  assign w_timeout = (w_cnt_inc == 17'(MEM_TIMEOUT)) & ~i_dmem_ready;

  always_comb begin
    w_state_d     = r_state_q;
    w_wait_cnt_d  = 16'd0;
    w_err_d       = r_err_q;
    w_pc_en       = 1'b0;
    w_if_id_en    = 1'b0;
    w_id_ex_en    = 1'b0;
    w_ex_mem_en   = 1'b0;
    w_mem_wb_en   = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_dmem_req    = 1'b0;
    w_halted      = 1'b0;
    unique case (r_state_q)
      StRun: begin
        w_dmem_req = i_mem_is_mem;
        if (w_mem_stall) begin
          w_state_d = StMemWait;
        end else begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
          if (i_ex_branch_taken) begin
            // A branch discards the ID instruction, so any load-use match is moot.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end
          if (i_dbg_halt_req) w_state_d = StHalted;
        end
      end
      StMemWait: begin
        w_dmem_req = 1'b1;
        if (i_dmem_ready || w_timeout) begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
          w_if_id_flush = i_ex_branch_taken;
          w_id_ex_flush = i_ex_branch_taken;
          w_state_d     = StRun;
          if (w_timeout) w_err_d = 1'b1;
        end else begin
          w_wait_cnt_d = w_cnt_inc[15:0];
        end
      end
      StHalted: begin
        w_halted = 1'b1;
        if (i_dbg_resume) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state_q    <= StRun;
      r_wait_cnt_q <= 16'd0;
      r_err_q      <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_wait_cnt_q <= w_wait_cnt_d;
      r_err_q      <= w_err_d;
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign o_pc_en           = w_pc_en       & i_rst_n;
  assign o_if_id_en        = w_if_id_en    & i_rst_n;
  assign o_id_ex_en        = w_id_ex_en    & i_rst_n;
  assign o_ex_mem_en       = w_ex_mem_en   & i_rst_n;
  assign o_mem_wb_en       = w_mem_wb_en   & i_rst_n;
  assign o_if_id_flush     = w_if_id_flush & i_rst_n;
  assign o_id_ex_flush     = w_id_ex_flush & i_rst_n;
  assign o_dmem_req        = w_dmem_req    & i_rst_n;
  assign o_halted          = w_halted      & i_rst_n;
  assign o_mem_timeout_err = r_err_q       & i_rst_n;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles_q <= 32'd0;
    end else if (!w_pc_en && (r_stall_cycles_q != 32'hFFFF_FFFF)) begin
      r_stall_cycles_q <= r_stall_cycles_q + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles_q;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4). Expected control
// vectors are queued as each cycle's stimulus is applied and compared at
// the following falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
  logic        mem_is_mem, dmem_ready, dbg_halt_req, dbg_resume;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, dmem_req, halted, mem_timeout_err;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4)) u_dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_id_rs1_idx      (id_rs1_idx),
    .i_id_rs2_idx      (id_rs2_idx),
    .i_id_uses_rs1     (id_uses_rs1),
    .i_id_uses_rs2     (id_uses_rs2),
    .i_ex_rd_idx       (ex_rd_idx),
    .i_ex_is_load      (ex_is_load),
    .i_ex_branch_taken (ex_branch_taken),
    .i_mem_is_mem      (mem_is_mem),
    .i_dmem_ready      (dmem_ready),
    .i_dbg_halt_req    (dbg_halt_req),
    .i_dbg_resume      (dbg_resume),
    .o_pc_en           (pc_en),
    .o_if_id_en        (if_id_en),
    .o_id_ex_en        (id_ex_en),
    .o_ex_mem_en       (ex_mem_en),
    .o_mem_wb_en       (mem_wb_en),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_flush     (id_ex_flush),
    .o_dmem_req        (dmem_req),
    .o_halted          (halted),
    .o_mem_timeout_err (mem_timeout_err),
    .o_stall_cycles    (stall_cycles)
  );

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, dmem_req, halted, err}
  logic [9:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, dmem_req, halted, mem_timeout_err};

  localparam logic [9:0] CNorm  = 10'b11111_00_0_0_0;
  localparam logic [9:0] CLoadU = 10'b00111_01_0_0_0;
  localparam logic [9:0] CBr    = 10'b11111_11_0_0_0;
  localparam logic [9:0] CStall = 10'b00000_00_1_0_0;
  localparam logic [9:0] CRel   = 10'b11111_00_1_0_0;
  localparam logic [9:0] CRelBr = 10'b11111_11_1_0_0;
  localparam logic [9:0] CHalt  = 10'b00000_00_0_1_0;

  typedef struct {
    string      tag;
    logic [9:0] ctl;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_stall = 0;
  logic        err_bit = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with this cycle's inputs already applied.
  task automatic step(input string tag, input logic [9:0] exp_ctl);
    exp_t e;
    e.tag = tag;
    e.ctl = exp_ctl | {9'd0, err_bit};
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq(e.tag, {22'd0, ctl}, {22'd0, e.ctl});
    check_eq({e.tag, "_perf"}, stall_cycles, exp_stall);
    if (PerfEn && !e.ctl[9]) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1_idx = 5'd1; id_rs2_idx = 5'd2; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd_idx = 5'd3; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_is_mem = 1'b0; dmem_ready = 1'b0; dbg_halt_req = 1'b0; dbg_resume = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    mem_is_mem = 1'b1;
    #3;
    check_eq("reset_ctl", {22'd0, ctl}, 32'd0);
    check_eq("reset_perf", stall_cycles, 32'd0);
    mem_is_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("idle", CNorm);

    // Load-use through rs1, then the bubble passes.
    ex_is_load = 1'b1; ex_rd_idx = 5'd5; id_rs1_idx = 5'd5; id_uses_rs1 = 1'b1;
    step("lu_rs1", CLoadU);
    ex_is_load = 1'b0;
    step("lu_after", CNorm);

    // rd = x0 never stalls.
    ex_is_load = 1'b1; ex_rd_idx = 5'd0; id_rs1_idx = 5'd0;
    step("lu_x0", CNorm);

    // rs2 match counts only when rs2 is used.
    set_idle();
    ex_is_load = 1'b1; ex_rd_idx = 5'd9; id_rs2_idx = 5'd9; id_uses_rs2 = 1'b1;
    step("lu_rs2", CLoadU);
    id_uses_rs2 = 1'b0;
    step("lu_rs2_unused", CNorm);

    // Branch wins over a simultaneous load-use hazard.
    id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
    step("br_lu", CBr);
    set_idle();
    step("br_after", CNorm);

    // Memory ready three cycles after the request.
    mem_is_mem = 1'b1;
    step("mw_req", CStall);
    step("mw_w1", CStall);
    step("mw_w2", CStall);
    dmem_ready = 1'b1;
    step("mw_rel", CRel);
    set_idle();
    step("mw_after", CNorm);

    // Ready in the request cycle costs nothing.
    mem_is_mem = 1'b1; dmem_ready = 1'b1;
    step("mem_fast", CRel);
    set_idle();

    // Branch in EX during the release cycle applies its flushes.
    mem_is_mem = 1'b1;
    step("mwbr_req", CStall);
    dmem_ready = 1'b1; ex_branch_taken = 1'b1;
    step("mwbr_rel", CRelBr);
    set_idle();
    step("mwbr_after", CNorm);

    // Timeout: forced release in the fourth MEM_WAIT cycle, flag is sticky.
    mem_is_mem = 1'b1;
    step("to_req", CStall);
    step("to_w1", CStall);
    step("to_w2", CStall);
    step("to_w3", CStall);
    step("to_rel", CRel);
    err_bit = 1'b1;
    mem_is_mem = 1'b0;
    step("to_sticky", CNorm);

    // Halt during a memory stall waits for the access to finish.
    mem_is_mem = 1'b1; dbg_halt_req = 1'b1;
    step("hm_req", CStall);
    step("hm_w1", CStall);
    dmem_ready = 1'b1;
    step("hm_rel", CRel);
    mem_is_mem = 1'b0; dmem_ready = 1'b0;
    step("hm_run", CNorm);
    mem_is_mem = 1'b1;
    step("hm_halted", CHalt);
    dbg_halt_req = 1'b0; dbg_resume = 1'b1;
    step("hm_resume", CHalt);
    dbg_resume = 1'b0; mem_is_mem = 1'b0;
    step("hm_running", CNorm);

    // Asynchronous reset in the middle of a MEM_WAIT cycle.
    mem_is_mem = 1'b1;
    step("rst_req", CStall);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_ctl", {22'd0, ctl}, 32'd0);
    check_eq("rst_async_perf", stall_cycles, 32'd0);
    err_bit = 1'b0;
    exp_stall = 0;
    mem_is_mem = 1'b0;
    #1;
    rst_n = 1'b1;
    step("rst_run", CNorm);
    step("rst_run2", CNorm);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage core. Drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses. Also supports a debug halt/resume. Sits beside the datapath and receives hazard-relevant fields from the ID, EX and MEM stages.

## Interface
- MEM_TIMEOUT, default 255: maximum cycles spent in MEM_WAIT before forced release; legal range 1..65535.
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1_idx, id_rs2_idx  in  5 each  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
- ex_rd_idx  in  5  destination index of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_is_mem  in  1  EX/MEM register holds a load or store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dbg_halt_req, dbg_resume  in  1 each  debug halt request (level); resume (pulse).
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register / PC load enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (zero) into the register on this edge.
- dmem_req  out  1  data-memory access request.
- halted  out  1  pipeline frozen in HALTED.
- mem_timeout_err  out  1  sticky timeout flag.
- stall_cycles  out  32  stall performance counter (see Configuration).

## Operation
- FSM states: RUN, MEM_WAIT, HALTED. Reset state: RUN.
- All control outputs are combinational from the current state and the inputs.
- While rst_n=0, every output is 0.
- dmem_req = (RUN & mem_is_mem) | MEM_WAIT.
- RUN priority, highest first:
  1. Memory stall: mem_is_mem=1 and dmem_ready=0. All five enables are 0, no flushes, next state MEM_WAIT.
  2. Taken branch: ex_branch_taken=1. All enables are 1, if_id_flush=1, id_ex_flush=1.
  3. Load-use hazard: ex_is_load=1, ex_rd_idx≠0, and (id_uses_rs1 & id_rs1_idx==ex_rd_idx | id_uses_rs2 & id_rs2_idx==ex_rd_idx). pc_en=0, if_id_en=0, id_ex_flush=1; id_ex_en, ex_mem_en, mem_wb_en are 1.
  4. Otherwise all enables are 1 and no flushes.
- A branch and a load-use hazard in the same cycle are handled as a branch only; the ID instruction is discarded.
- Halt in RUN: if dbg_halt_req=1 and no memory stall is pending, go to HALTED at the next edge. The current cycle still advances per the priorities above. A pending memory access is completed first.
- MEM_WAIT:
  - All enables are 0.
  - On dmem_ready=1: all enables are 1 that cycle, next state RUN. A branch in EX that cycle also applies its flushes.
  - The wait counter increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT without dmem_ready: set mem_timeout_err, release exactly as if ready, return to RUN.
- HALTED: all enables are 0, halted=1, dmem_req=0. A dbg_resume pulse returns to RUN at the next edge; dbg_halt_req is ignored in HALTED.
- mem_timeout_err clears only on reset.
- Reset mid-operation (any state): asynchronous return to RUN. Wait counter and error flag clear; the perf counter clears.

## Timing
- Stall and flush decisions take effect on the same edge as the hazard cycle; there is zero added latency.
- A load-use hazard costs exactly 1 bubble cycle.
- A taken branch costs 2 flushed slots.
- Memory access with ready in the request cycle: 0 stall cycles. Ready N cycles after the request: N stall cycles.
- Halt entry: 1 cycle after dbg_halt_req is seen in RUN with no memory stall. Resume: 1 cycle after the dbg_resume pulse.
- Wait counter is 16 bits. It resets to 0 on MEM_WAIT entry and on exit.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles counts cycles with rst_n=1 and pc_en=0, saturating at 0xFFFFFFFF. It resets to 0.
- PIPE_CTRL_PERF_EN undefined: no counter logic; stall_cycles is tied to 0.

## Test plan
- Load-use: EX load with rd=5, ID reads rs1=5. Expect one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then normal flow. Repeat with rd=0: expect no stall.
- Branch plus hazard: ex_branch_taken=1 together with a load-use match. Expect if_id_flush=1, id_ex_flush=1, pc_en=1, and no stall cycle.
- Memory wait: mem_is_mem=1 with dmem_ready raised 3 cycles later. Expect dmem_req high for 4 cycles and all enables 0 for 3 cycles, then 1. With PERF_EN, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4 and dmem_ready held 0. Expect release after 4 MEM_WAIT cycles, mem_timeout_err=1, and the flag persisting until rst_n pulses low.
- Halt during memory: dbg_halt_req asserted in a memory-stall cycle. Expect HALTED only after dmem_ready. Then dbg_resume returns to RUN 1 cycle later with halted=0.
- Async reset in MEM_WAIT: assert rst_n=0 mid-clock. Expect all outputs 0 immediately; after release, state is RUN, err=0 and stall_cycles=0.
